// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises and deglitches the PS/2 lines,
// deframes start/8 data/odd parity/stop, and buffers accepted bytes in a
// first-word-fall-through FIFO with registered outputs and error pulses.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 16,
  parameter bit CHECK_PARITY   = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            timeout_err,
  output logic                            overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_s;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;
  logic          push_s;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          ovf_q, ovf_d;
  logic          pop_s, full_s, wr_en_s;

  // Deglitch filter: flip the filtered clock once the synchronised level has differed for FILTER_LEN cycles.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = {FW{1'b0}};
    fall_s     = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_s2_q;
        filt_cnt_d = {FW{1'b0}};
        fall_s     = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_ONE;
      end
    end else begin
      filt_cnt_d = {FW{1'b0}};
    end
  end

  // Frame deserialiser with inter-edge timeout; errors and the push decision come from the stop-bit sample.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    terr_d    = 1'b0;
    push_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_s && !dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          shift_d   = 8'd0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = ST_PARITY;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_d = ST_IDLE;
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if ((CHECK_PARITY == 1'b1) && !odd_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // An open frame that stalls for TIMEOUT_CYCLES is abandoned.
    if (state_q != ST_IDLE) begin
      if (fall_s) begin
        tmo_d = {TW{1'b0}};
      end else if (tmo_q == TMO_LAST) begin
        tmo_d     = {TW{1'b0}};
        terr_d    = 1'b1;
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
        shift_d   = 8'd0;
      end else begin
        tmo_d = tmo_q + TMO_ONE;
      end
    end else begin
      tmo_d = {TW{1'b0}};
    end
  end

  // FIFO bookkeeping; the next head byte is precomputed so rx_data leaves a flop.
  always_comb begin
    pop_s    = rd_en & rx_valid_q;
    full_s   = (count_q == CNT_FULL);
    wr_en_s  = push_s & (~full_s | pop_s);
    ovf_d    = push_s & full_s & ~pop_s;
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    rx_valid_d = (count_d != {CW{1'b0}});
    if (count_d == {CW{1'b0}}) begin
      rx_data_d = 8'd0;
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      rx_data_d = shift_q;
    end else begin
      rx_data_d = mem_q[rd_ptr_d];
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= {FW{1'b0}};
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      tmo_q      <= {TW{1'b0}};
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      terr_q     <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      terr_q     <= terr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign fifo_count  = count_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronised samples required to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: clk cycles without a filtered falling edge before an open frame is aborted.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: received-byte buffer depth, power of two, at least 2.
REQ-004 SHALL have parameter CHECK_PARITY, default 1: 1 = odd parity enforced, 0 = parity bit ignored.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port ps2_clk, input, 1: asynchronous PS/2 clock line from the device.
REQ-008 SHALL have port ps2_data, input, 1: asynchronous PS/2 data line from the device.
REQ-009 SHALL have port rd_en, input, 1: pop the FIFO head when rx_valid=1.
REQ-010 SHALL have port rx_data, output, 8: FIFO head byte, first-word-fall-through.
REQ-011 SHALL have port rx_valid, output, 1: FIFO non-empty.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1): bytes stored.
REQ-013 SHALL have port parity_err, output, 1: one-cycle pulse, frame dropped for bad parity.
REQ-014 SHALL have port frame_err, output, 1: one-cycle pulse, frame dropped for stop bit = 0.
REQ-015 SHALL have port timeout_err, output, 1: one-cycle pulse, open frame aborted by timeout.
REQ-016 SHALL have port overflow, output, 1: one-cycle pulse, valid byte dropped because the FIFO was full.

Function
REQ-017 SHALL pass ps2_clk and ps2_data each through a two-flop synchroniser before any use.
REQ-018 SHALL change the filtered clock only after the synchronised ps2_clk has held a new level for FILTER_LEN consecutive cycles; shorter glitches produce no edge.
REQ-019 SHALL define a sample event as a 1-to-0 transition of the filtered clock, and SHALL sample synchronised ps2_data in that cycle.
REQ-020 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-021 In IDLE, on a sample event with data=0 (start bit), SHALL enter DATA with bit counter 0 and the timeout counter cleared; a sample event with data=1 SHALL be ignored.
REQ-022 In DATA, SHALL shift in 8 bits LSB-first, one per sample event, then enter PARITY.
REQ-023 In PARITY, SHALL capture the parity bit and enter STOP.
REQ-024 In STOP, on a sample event: data=0 -> frame_err pulse, no push; data=1 and parity failed (XOR of 8 data bits and parity bit = 0) with CHECK_PARITY=1 -> parity_err pulse, no push; otherwise push the byte. All cases return to IDLE.
REQ-025 When both the stop bit and parity are bad, SHALL report frame_err only.
REQ-026 Outside IDLE, SHALL count clk cycles since the last sample event; on reaching TIMEOUT_CYCLES, SHALL pulse timeout_err, discard the partial frame and enter IDLE.
REQ-027 Error pulses SHALL be asserted in the cycle after the deciding sample event or timeout.
REQ-028 A pushed byte SHALL appear on rx_data with rx_valid=1 in the cycle after the accepting stop-bit sample event, provided the FIFO was empty.
REQ-029 rd_en with rx_valid=1 SHALL pop the head; the next entry or rx_valid=0 SHALL appear the following cycle. rd_en while empty SHALL be ignored.
REQ-030 A push while full without a simultaneous pop SHALL drop the new byte, pulse overflow, and leave contents unchanged.
REQ-031 A simultaneous push and pop SHALL both take effect, including when full; fifo_count SHALL stay unchanged.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-033 While rst=1 on a clk edge, SHALL set the FSM to IDLE; clear counters, pointers, fifo_count and the shift register; drive rx_data=0, rx_valid=0 and all error pulses 0; set the filtered clock and synchronisers to 1.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release, the first frame SHALL be received only from its start bit.

Verification
REQ-035 Send frame 0x1C with parity 0 -> rx_data=0x1C, rx_valid=1 and fifo_count=1 one cycle after the stop edge; no error pulse.
REQ-036 Send 0x1C with parity 1 (CHECK_PARITY=1) -> parity_err single pulse, fifo_count stays 0; repeat with CHECK_PARITY=0 -> byte pushed.
REQ-037 Send 0xF0 with stop bit 0 -> frame_err single pulse, no push; insert a ps2_clk low glitch of FILTER_LEN-1 cycles -> no bit consumed.
REQ-038 Send start bit plus 3 data bits, then idle TIMEOUT_CYCLES -> timeout_err single pulse, FSM back in IDLE; the next full frame 0x55 is received correctly.
REQ-039 Send FIFO_DEPTH+1 frames without reads -> fifo_count=FIFO_DEPTH and overflow pulses on the last frame; read all -> bytes out in order, then rx_valid=0.
REQ-040 Assert rst after 5 data bits -> outputs at reset values; after release, frame 0xA3 -> rx_data=0xA3, fifo_count=1.
